// File: rtl/uart_fifo_transmitter.sv
// uart_fifo_transmitter: UART TX that pops words from a FWFT FIFO and serialises them at 16x oversample.
// Optional even parity bit enabled by defining UART_TX_PARITY_EN.
module uart_fifo_transmitter #(
  parameter int DBIT    = 8,
  parameter int SB_TICK = 16,
  parameter int DVSR    = 326
) (
  input  logic            i_clk,
  input  logic            i_reset,
  input  logic            i_fifo_empty,
  input  logic [DBIT-1:0] i_fifo_data,
  output logic            o_fifo_rd,
  output logic            o_tx,
  output logic            o_tx_busy,
  output logic            o_tx_done_tick
);
  localparam int CW = DVSR > 1 ? $clog2(DVSR) : 1;
  localparam int TW = SB_TICK > 16 ? $clog2(SB_TICK) : 4;
  localparam int NW = DBIT > 1 ? $clog2(DBIT) : 1;
  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
`ifdef UART_TX_PARITY_EN
    PARITY,
`endif
    STOP
  } state_t;
  state_t state, state_n;
  logic [CW-1:0] cnt, cnt_n;
  logic [TW-1:0] s, s_n;
  logic [NW-1:0] n, n_n;
  logic [DBIT-1:0] b, b_n;
  logic tx, tx_n, rd, done, tick;
  assign tick = state != IDLE && cnt == CW'(DVSR - 1);
  assign cnt_n = (state == IDLE || tick) ? '0 : cnt + 1'b1;
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      state <= IDLE;
      cnt   <= '0;
      s     <= '0;
      n     <= '0;
      b     <= '0;
      tx    <= 1'b1;
    end else begin
      state <= state_n;
      cnt   <= cnt_n;
      s     <= s_n;
      n     <= n_n;
      b     <= b_n;
      tx    <= tx_n;
    end
  end
  // The word rotates rather than shifts, so after DBIT bits it is whole again for parity.
  always_comb begin
    state_n = state;
    s_n     = s;
    n_n     = n;
    b_n     = b;
    tx_n    = tx;
    rd      = 1'b0;
    done    = 1'b0;
    case (state)
      IDLE:
        if (!i_fifo_empty) begin
          b_n     = i_fifo_data;
          rd      = 1'b1;
          tx_n    = 1'b0;
          state_n = START;
        end
      START:
        if (tick) begin
          s_n = s + 1'b1;
          if (s == TW'(15)) begin
            s_n     = '0;
            tx_n    = b[0];
            state_n = DATA;
          end
        end
      DATA:
        if (tick) begin
          s_n = s + 1'b1;
          if (s == TW'(15)) begin
            s_n  = '0;
            b_n  = {b[0], b[DBIT-1:1]};
            tx_n = b_n[0];
            n_n  = n + 1'b1;
            if (n == NW'(DBIT - 1)) begin
              n_n     = '0;
`ifdef UART_TX_PARITY_EN
              tx_n    = ^b;
              state_n = PARITY;
`else
              tx_n    = 1'b1;
              state_n = STOP;
`endif
            end
          end
        end
`ifdef UART_TX_PARITY_EN
      PARITY:
        if (tick) begin
          s_n = s + 1'b1;
          if (s == TW'(15)) begin
            s_n     = '0;
            tx_n    = 1'b1;
            state_n = STOP;
          end
        end
`endif
      STOP:
        if (tick) begin
          s_n = s + 1'b1;
          if (s == TW'(SB_TICK - 1)) begin
            s_n     = '0;
            done    = 1'b1;
            state_n = IDLE;
          end
        end
      default: state_n = IDLE;
    endcase
  end
  assign o_fifo_rd      = rd & ~i_reset;
  assign o_tx_done_tick = done & ~i_reset;
  assign o_tx           = tx;
  assign o_tx_busy      = state != IDLE;
endmodule

// File: tb/tb_uart_fifo_transmitter.sv
// tb_uart_fifo_transmitter: scoreboard bench; stimulus queues expected bytes, a line monitor decodes and compares frames.
module tb_uart_fifo_transmitter;
  localparam int DV = 4;
  localparam int BT = 16 * DV;
`ifdef UART_TX_PARITY_EN
  localparam int P = 1;
`else
  localparam int P = 0;
`endif
  localparam int FLEN = BT * (10 + P);

  logic clk = 0, rst = 1, fifo_empty = 1, push_v = 0, empty2 = 1;
  logic [7:0] fifo_data = 8'hA5, push_d = 8'h00;
  logic rd, tx, busy, done, rd2, tx2, busy2, done2;
  logic [7:0] fifo[$];
  logic [7:0] exp_q[$];
  int nchk = 0, nerr = 0, cyc = 0, pops = 0;
  int k = 0, last_done = -10, b2b = 0, frames = 0, aborts = 0, wbad = 0;
  bit active = 0;
  logic [7:0] cur = 0, dec = 0;

  always #5 clk = ~clk;

  uart_fifo_transmitter #(.DBIT(8), .SB_TICK(16), .DVSR(DV)) dut (
    .i_clk(clk), .i_reset(rst), .i_fifo_empty(fifo_empty), .i_fifo_data(fifo_data),
    .o_fifo_rd(rd), .o_tx(tx), .o_tx_busy(busy), .o_tx_done_tick(done)
  );

  uart_fifo_transmitter #(.DBIT(8), .SB_TICK(32), .DVSR(DV)) dut2 (
    .i_clk(clk), .i_reset(rst), .i_fifo_empty(empty2), .i_fifo_data(8'h30),
    .o_fifo_rd(rd2), .o_tx(tx2), .o_tx_busy(busy2), .o_tx_done_tick(done2)
  );

  task automatic chk(input string name, input int act, input int exp);
    nchk++;
    if (act != exp) begin
      nerr++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  function automatic logic exp_bit(input logic [7:0] v, input int kk);
    int j;
    j = kk / BT;
    if (j == 0) return 1'b0;
    if (j <= 8) return v[j-1];
    if (P == 1 && j == 9) return ^v;
    return 1'b1;
  endfunction

  always @(posedge clk) cyc <= cyc + 1;

  // FWFT FIFO model feeding the main DUT
  always @(posedge clk) begin
    if (rd) begin
      pops <= pops + 1;
      if (fifo.size() == 0) chk("pop_when_empty", 1, 0);
      else void'(fifo.pop_front());
    end
    if (push_v) fifo.push_back(push_d);
    fifo_empty <= (fifo.size() == 0);
    fifo_data  <= (fifo.size() != 0) ? fifo[0] : 8'hA5;
  end

  // Line monitor: checks every cycle of each frame against the expected byte at the queue head
  initial forever begin
    @(negedge clk);
    if (rst) begin
      if (active) begin
        aborts++;
        if (exp_q.size() != 0) void'(exp_q.pop_front());
      end
      active = 0;
    end else begin
      if (done && !(active && k == FLEN - 1)) chk("stray_done", 1, 0);
      if (done && rd) chk("done_rd_overlap", 1, 0);
      if (!active && !tx) begin
        active = 1;
        k = 0;
        wbad = 0;
        dec = 0;
        if (cyc - last_done == 2) b2b++;
        if (exp_q.size() == 0) begin
          chk("unexpected_frame", 1, 0);
          cur = 8'h00;
        end else cur = exp_q[0];
      end
      if (active) begin
        if (tx !== exp_bit(cur, k)) wbad++;
        if (k % BT == BT / 2 && k / BT >= 1 && k / BT <= 8) dec[k/BT-1] = tx;
        if (k == FLEN - 1) begin
          chk("done_at_frame_end", int'(done), 1);
          chk("frame_wave", wbad, 0);
          chk("byte", int'(dec), int'(cur));
          if (exp_q.size() != 0) void'(exp_q.pop_front());
          frames++;
          last_done = cyc;
          active = 0;
        end else k++;
      end
    end
  end

  task automatic push(input logic [7:0] v);
    push_d = v;
    push_v = 1;
    exp_q.push_back(v);
    @(posedge clk);
    #1 push_v = 0;
  endtask

  task automatic wait_frames(input int n, input int budget);
    for (int i = 0; i < budget && frames < n; i++) @(posedge clk);
    #1;
    chk("frames_done", frames, n);
  endtask

  initial begin
    int bad, run, t, b0;
    repeat (3) @(posedge clk);
    #1 rst = 0;
    @(negedge clk);
    chk("rst_tx", int'(tx), 1);
    chk("rst_busy", int'(busy), 0);
    chk("rst_rd", int'(rd), 0);
    chk("rst_done", int'(done), 0);
    bad = 0;
    for (int i = 0; i < 2000; i++) begin
      @(negedge clk);
      if (tx !== 1'b1 || rd !== 1'b0 || busy !== 1'b0) bad++;
    end
    chk("idle_quiet", bad, 0);
    @(posedge clk);
    #1;
    push(8'h34);
    wait_frames(1, FLEN + 100);
    chk("pops_single", pops, 1);
    b0 = b2b;
    push(8'h34);
    push(8'h2E);
    push(8'h32);
    push(8'h37);
    wait_frames(5, 4 * FLEN + 200);
    chk("pops_burst", pops, 5);
    chk("b2b_gaps", b2b - b0, 3);
    push(8'h39);
    for (int i = 0; i < 2000 && !(active && k == BT * 4 + 20); i++) @(posedge clk);
    chk("reached_bit3", int'(active), 1);
    #1 rst = 1;
    @(posedge clk);
    #1 rst = 0;
    @(negedge clk);
    chk("abort_tx_high", int'(tx), 1);
    chk("abort_busy", int'(busy), 0);
    chk("aborts", aborts, 1);
    repeat (FLEN) @(posedge clk);
    #1;
    chk("no_frame_after_abort", frames, 5);
    push(8'h30);
    wait_frames(6, FLEN + 100);
    chk("pops_after_abort", pops, 7);
    push(8'h35);
    push(8'h37);
    wait_frames(8, 2 * FLEN + 100);
    chk("pops_parity_pair", pops, 9);
    empty2 = 0;
    t = 0;
    for (int i = 0; i < 20 && rd2 !== 1'b1; i++) @(negedge clk);
    chk("dut2_pop", int'(rd2), 1);
    @(posedge clk);
    #1 empty2 = 1;
    run = 0;
    for (int i = 0; i < 3000; i++) begin
      @(negedge clk);
      run = (tx2 === 1'b1) ? run + 1 : 0;
      if (done2 === 1'b1) break;
      t++;
    end
    chk("dut2_stop_run", run, 128);
    chk("dut2_done_offset", t, BT * (9 + P) + 128 - 1);
    @(negedge clk);
    chk("dut2_idle_busy", int'(busy2), 0);
    chk("scoreboard_empty", exp_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", nchk, nerr);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL timeout: simulation exceeded time limit");
    $fatal(1);
  end
endmodule
